// File: rtl/seq_pair_loader.sv
//==============================================================================
// Module  : seq_pair_loader
// Brief   : Ping-pong loader assembling query/database chunk pairs into two banks
// Revision: 1.0
//==============================================================================
`default_nettype none

module seq_pair_loader #(
  parameter  int SEQ_LENGTH   = 16,
  parameter  int LETTER_WIDTH = 2,
  parameter  int INPUT_WIDTH  = 8,
  localparam int LPC          = INPUT_WIDTH / LETTER_WIDTH,
  localparam int NUM_CHUNKS   = SEQ_LENGTH / LPC,
  localparam int LEN_W        = $clog2(NUM_CHUNKS + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    in_last,
  input  logic [INPUT_WIDTH-1:0]                  query_in,
  input  logic [INPUT_WIDTH-1:0]                  database_in,
  output logic                                    out_valid,
  input  logic                                    out_release,
  output logic [SEQ_LENGTH-1:0][LETTER_WIDTH-1:0] query_out,
  output logic [SEQ_LENGTH-1:0][LETTER_WIDTH-1:0] database_out,
  output logic [LEN_W-1:0]                        out_len
);

  localparam int CNT_W = $clog2(NUM_CHUNKS);

  logic [1:0][SEQ_LENGTH-1:0][LETTER_WIDTH-1:0] q_mem;
  logic [1:0][SEQ_LENGTH-1:0][LETTER_WIDTH-1:0] d_mem;
  logic [1:0][LEN_W-1:0]                        bank_len;
  logic [1:0]                                   bank_full;
  logic                                         wr_bank;
  logic                                         rd_bank;
  logic [CNT_W-1:0]                             chunk_cnt;

  logic                                         accept;
  logic                                         close_fill;
  logic                                         release_bank;
  logic [SEQ_LENGTH-1:0]                        letter_hit;
  logic [SEQ_LENGTH-1:0][LETTER_WIDTH-1:0]      q_letter;
  logic [SEQ_LENGTH-1:0][LETTER_WIDTH-1:0]      d_letter;

  assign in_ready     = !bank_full[wr_bank];
  assign accept       = in_valid && in_ready;
  assign close_fill   = accept && (in_last || (chunk_cnt == CNT_W'(NUM_CHUNKS - 1)));
  assign release_bank = out_release && bank_full[rd_bank];

  // Each letter slot knows which chunk feeds it and from which lane of that chunk.
  for (genvar l = 0; l < SEQ_LENGTH; l++) begin : g_letter
    assign letter_hit[l] = (chunk_cnt == CNT_W'(l / LPC));
    assign q_letter[l]   = query_in[(l % LPC)*LETTER_WIDTH +: LETTER_WIDTH];
    assign d_letter[l]   = database_in[(l % LPC)*LETTER_WIDTH +: LETTER_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_mem     <= '0;
      d_mem     <= '0;
      bank_len  <= '0;
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      chunk_cnt <= '0;
    end else begin
      if (accept) begin
        // Chunk 0 wipes the bank so a short pair reads back zero-padded.
        for (int l = 0; l < SEQ_LENGTH; l++) begin
          if (letter_hit[l]) begin
            q_mem[wr_bank][l] <= q_letter[l];
            d_mem[wr_bank][l] <= d_letter[l];
          end else if (chunk_cnt == '0) begin
            q_mem[wr_bank][l] <= '0;
            d_mem[wr_bank][l] <= '0;
          end
        end
        if (close_fill) begin
          bank_full[wr_bank] <= 1'b1;
          bank_len[wr_bank]  <= LEN_W'(chunk_cnt) + LEN_W'(1);
          chunk_cnt          <= '0;
          wr_bank            <= ~wr_bank;
        end else begin
          chunk_cnt <= chunk_cnt + CNT_W'(1);
        end
      end
      // A releasable bank is full, so it can never be the bank being written.
      if (release_bank) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
    end
  end

  assign out_valid    = bank_full[rd_bank];
  assign query_out    = q_mem[rd_bank];
  assign database_out = d_mem[rd_bank];
  assign out_len      = bank_len[rd_bank];

endmodule

`default_nettype wire

// File: doc/seq_pair_loader.md
# seq_pair_loader

Parametrised, double-buffered (ping-pong) loader for query/database sequence pairs. It accepts `INPUT_WIDTH`-bit chunks of both sequences over a valid/ready handshake and assembles them into two banks of `SEQ_LENGTH` letters. It supports short sequences through an `in_last` marker with zero padding. While the scoring matrix consumes one completed pair, the next pair loads into the other bank. The block sits between the input interface and the scoring matrix, in place of the single-bank counter-addressed buffer.

## Interface
- `SEQ_LENGTH`, 16: letters per sequence (bank capacity).
- `LETTER_WIDTH`, 2: bits per letter.
- `INPUT_WIDTH`, 8: bits per input chunk. Must be a multiple of `LETTER_WIDTH`.
- Derived `LPC` = `INPUT_WIDTH/LETTER_WIDTH`: letters per chunk.
- Derived `NUM_CHUNKS` = `SEQ_LENGTH/LPC`: chunks per full sequence. `SEQ_LENGTH` must be a multiple of `LPC`, and `NUM_CHUNKS` ≥ 2.
- Derived `LEN_W` = `$clog2(NUM_CHUNKS+1)`.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: chunk pair present on `query_in`/`database_in`.
- `in_ready` output 1: loader can accept a chunk this cycle.
- `in_last` input 1: current chunk is the last one of this pair (early termination).
- `query_in` input `INPUT_WIDTH`: query chunk.
- `database_in` input `INPUT_WIDTH`: database chunk.
- `out_valid` output 1: the read bank holds a complete pair.
- `out_release` input 1: consumer finished with the read bank. Single-cycle pulse.
- `query_out` output `[SEQ_LENGTH-1:0][LETTER_WIDTH-1:0]`: query letters of the read bank.
- `database_out` output `[SEQ_LENGTH-1:0][LETTER_WIDTH-1:0]`: database letters of the read bank.
- `out_len` output `LEN_W`: number of valid chunks in the read bank. Valid letters = `out_len*LPC`.

## Operation
- **State**
  - Two banks, each with a query register array, a database register array, a `len` register, and a `full` flag.
  - `wr_bank` and `rd_bank` pointers, 1 bit each.
  - `chunk_cnt` counter, 0..`NUM_CHUNKS-1`.
- **Per-bank states:** EMPTY → FILLING (`chunk_cnt` > 0 on `wr_bank`) → FULL → EMPTY.
- **Handshake:** `in_ready` = `!full[wr_bank]`. A chunk is accepted on a cycle with `in_valid && in_ready`. `in_valid` held without `in_ready` is a stall and is not an error.
- **Accepting a chunk:** letters `chunk_cnt*LPC .. chunk_cnt*LPC+LPC-1` of `wr_bank` are written from the chunk's LSB letter upward. Chunk 0 carries letters 0..`LPC-1` and goes in at `query_in[LETTER_WIDTH-1:0]` = letter 0.
- **Chunk 0:** the entire `wr_bank` (query and database) is cleared to zero in the same cycle as the chunk-0 write. Unloaded letters therefore read as 0.
- **Closing a fill:** a fill closes when an accepted chunk has `in_last=1` or `chunk_cnt == NUM_CHUNKS-1`. On close:
  - `full[wr_bank]` ← 1.
  - `len[wr_bank]` ← `chunk_cnt+1`.
  - `chunk_cnt` ← 0.
  - `wr_bank` toggles.
- **Otherwise:** `chunk_cnt` increments.
- **Extra chunks:** `in_last` is ignored when no chunk is accepted. A sequence longer than `NUM_CHUNKS` chunks is split automatically; its remaining chunks form the next pair.
- **Output:** `out_valid` = `full[rd_bank]`. `query_out`, `database_out` and `out_len` mux combinationally from `rd_bank`. When `out_valid=0` they still show `rd_bank`'s registers, and those values are don't-care to the consumer.
- **Release:** `out_release && out_valid` sets `full[rd_bank]` ← 0 and toggles `rd_bank`. Bank contents are not cleared. `out_release` while `out_valid=0` is ignored.
- **Simultaneous fill-close and release on different banks:** both take effect in the same edge.
- **Simultaneous chunk accept and release on the same bank:** impossible, because `in_ready` requires the write bank to be non-full.

## Timing
- **Reset (asynchronous, immediate), all values:**
  - Bank arrays 0, `len` 0, `full` 0.
  - `wr_bank` = `rd_bank` = 0, `chunk_cnt` 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `query_out`=`database_out`=0, `out_len`=0.
- **Reset mid-fill or mid-consume:** the partial pair and any complete pairs are discarded. The next accepted chunk is chunk 0 of bank 0.
- **Latency:** `out_valid` rises the cycle after the edge that accepts the closing chunk, provided that bank is `rd_bank`.
- **Minimum fill time:** `NUM_CHUNKS` cycles from first chunk to `out_valid`.
- **Throughput:** one chunk per cycle, sustained, while the consumer releases each bank within `NUM_CHUNKS` cycles.
- **Backpressure:** when both banks are full, `in_ready`=0. It rises the cycle after the edge where `out_release` is sampled.
- **Registered signals:** `in_ready` and `out_valid` are functions of registered state only, with no combinational path from `in_valid` or `out_release`.

## Test plan
Configuration for all scenarios: `SEQ_LENGTH`=16, `LETTER_WIDTH`=2, `INPUT_WIDTH`=8, so `LPC`=4 and `NUM_CHUNKS`=4.

- **Reset:** with `rst_n`=0 → `in_ready`=1, `out_valid`=0, `out_len`=0, `query_out`=`database_out`=32'h0.
- **Full load:** query chunks 0x1B, 0x2C, 0x3D, 0x4E and database chunks 0xE4, 0xD3, 0xC2, 0xB1 on consecutive cycles, `in_last`=0 → `out_valid`=1 one cycle after the 4th accept, `query_out`=32'h4E3D2C1B, `database_out`=32'hB1C2D3E4, `out_len`=4.
- **Early last with padding:** preload bank 0 with all-ones and release it, then load two pairs (0xAA, 0x55) with `in_last` on the 2nd into bank 1, and later reuse bank 0 the same way → `query_out`=32'h000055AA, `out_len`=2. No stale ones are visible.
- **Backpressure:** three full pairs, no release → `in_ready`=0 after the 2nd pair closes and the 3rd pair's chunk 0 is held. Pulse `out_release` → `in_ready`=1 next cycle, outputs switch to pair 2, and the 3rd pair loads into bank 0.
- **Simultaneous events:** `out_release` on the same edge as the closing chunk of the other bank → the released bank goes EMPTY, the other goes FULL, and `out_valid` stays 1 with the new pair's data the next cycle. `out_release` with `out_valid`=0 → no state change.
- **Reset mid-fill:** 2 chunks accepted, pulse `rst_n` low → all outputs back to reset values. A subsequent 4-chunk load appears with `out_len`=4 from bank 0.
